// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the single-port SRAM port arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ARB_NONE = 2'd0,
    ARB_WR   = 2'd1,
    ARB_RD   = 2'd2
  } arb_grant_e;

  localparam int RSP_FIFO_DEPTH = 2;
  localparam int RSP_CNT_W      = 2;
  localparam int PERF_CNT_W     = 16;

endpackage

// File: rtl/sram_arb_chk.sv
// Protocol checker for the SRAM arbiter: response FIFO overflow, exclusive
// memory enables and the supported read latency.
module sram_arb_chk #(
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic rst_n,
  input logic fifo_push,
  input logic fifo_pop,
  input logic fifo_full,
  input logic ren,
  input logic wen
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_push && fifo_full && !fifo_pop));

  a_one_mem_op: assert property (@(posedge clk) disable iff (!rst_n)
    !(ren && wen));

  a_rd_lat_one: assert property (@(posedge clk) disable iff (!rst_n)
    (RD_LAT == 1));

endmodule

// File: rtl/sram_arb_rsp_fifo.sv
// Two-entry register FIFO holding read responses until the consumer takes them.
module sram_arb_rsp_fifo
  import sram_arb_pkg::*;
#(
  parameter int W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 push,
  input  logic [W-1:0]         push_data,
  input  logic                 pop,
  output logic [W-1:0]         pop_data,
  output logic [RSP_CNT_W-1:0] count,
  output logic                 full,
  output logic                 empty
);

  logic [W-1:0]         mem_r [RSP_FIFO_DEPTH];
  logic                 wr_ptr_r;
  logic                 rd_ptr_r;
  logic [RSP_CNT_W-1:0] count_r;
  logic                 do_push_s;
  logic                 do_pop_s;

  // A push into a full FIFO is only taken when a pop frees a slot that cycle
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  assign pop_data = mem_r[rd_ptr_r];
  assign count    = count_r;
  assign full     = (count_r == RSP_CNT_W'(RSP_FIFO_DEPTH));
  assign empty    = (count_r == {RSP_CNT_W{1'b0}});

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RSP_FIFO_DEPTH; i++) mem_r[i] <= {W{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= {RSP_CNT_W{1'b0}};
    end else if (clr) begin
      for (int i = 0; i < RSP_FIFO_DEPTH; i++) mem_r[i] <= {W{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= {RSP_CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + RSP_CNT_W'(1);
        2'b01:   count_r <= count_r - RSP_CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sram_sp_port_arbiter.sv
// Arbitrates one single-port SRAM between a write and a read requester.
// Optional SRAM_ARB_PERF_EN adds saturating conflict / read-block counters.
module sram_sp_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              tile_en,
  input  logic              cfg_write_priority,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_addr_valid,
  output logic              rd_addr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  input  logic              rd_data_ready,
  output logic [ADDR_W-1:0] addr_to_mem,
  output logic [DATA_W-1:0] data_to_mem,
  output logic              ren_to_mem,
  output logic              wen_to_mem,
  input  logic [DATA_W-1:0] data_from_mem
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_conflict_cnt,
  output logic [PERF_CNT_W-1:0] perf_rd_block_cnt
`endif
);

  logic                 active_s;
  logic                 clr_s;
  logic                 push_s;
  logic                 pop_s;
  logic [RSP_CNT_W-1:0] fifo_count_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [2:0]           rd_load_s;
  logic                 rd_ok_s;
  logic                 wr_req_s;
  logic                 rd_req_s;
  arb_grant_e           grant_s;
  arb_grant_e           last_grant_r;
  logic                 inflight_r;

  assign active_s = clk_en & tile_en & ~flush & rst_n;
  assign clr_s    = clk_en & flush;

  assign rd_data_valid = active_s & ~fifo_empty_s;
  assign pop_s         = rd_data_valid & rd_data_ready;
  assign push_s        = active_s & inflight_r;

  // Slots already committed (queued or in flight) after this cycle's pop
  assign rd_load_s = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign rd_ok_s   = (rd_load_s < 3'd2);
  assign wr_req_s  = wr_valid;
  assign rd_req_s  = rd_addr_valid & rd_ok_s;

  // Grant selection: single requester wins, conflicts by priority or round-robin
  always_comb begin
    grant_s = ARB_NONE;
    if (!active_s) begin
      grant_s = ARB_NONE;
    end else begin
      case ({wr_req_s, rd_req_s})
        2'b10: grant_s = ARB_WR;
        2'b01: grant_s = ARB_RD;
        2'b11: begin
          if (cfg_write_priority) begin
            grant_s = ARB_WR;
          end else if (last_grant_r == ARB_WR) begin
            grant_s = ARB_RD;
          end else begin
            grant_s = ARB_WR;
          end
        end
        default: grant_s = ARB_NONE;
      endcase
    end
  end

  // Memory pins and request handshakes driven from the grant
  always_comb begin
    wr_ready      = 1'b0;
    rd_addr_ready = 1'b0;
    wen_to_mem    = 1'b0;
    ren_to_mem    = 1'b0;
    addr_to_mem   = {ADDR_W{1'b0}};
    data_to_mem   = {DATA_W{1'b0}};
    case (grant_s)
      ARB_WR: begin
        wen_to_mem  = 1'b1;
        wr_ready    = 1'b1;
        addr_to_mem = wr_addr;
        data_to_mem = wr_data;
      end
      ARB_RD: begin
        ren_to_mem    = 1'b1;
        rd_addr_ready = 1'b1;
        addr_to_mem   = rd_addr;
      end
      default: begin
        wen_to_mem = 1'b0;
      end
    endcase
  end

  // Inflight read tracker and round-robin history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_r   <= 1'b0;
      last_grant_r <= ARB_WR;
    end else if (clr_s) begin
      inflight_r   <= 1'b0;
      last_grant_r <= ARB_WR;
    end else if (active_s) begin
      inflight_r <= (grant_s == ARB_RD);
      if (grant_s != ARB_NONE) begin
        last_grant_r <= grant_s;
      end
    end
  end

  sram_arb_rsp_fifo #(
    .W (DATA_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr_s),
    .push      (push_s),
    .push_data (data_from_mem),
    .pop       (pop_s),
    .pop_data  (rd_data),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  sram_arb_chk #(
    .RD_LAT (RD_LAT)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_push (push_s),
    .fifo_pop  (pop_s),
    .fifo_full (fifo_full_s),
    .ren       (ren_to_mem),
    .wen       (wen_to_mem)
  );

`ifdef SRAM_ARB_PERF_EN
  // Saturating performance counters, cleared with the rest of the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_conflict_cnt <= {PERF_CNT_W{1'b0}};
      perf_rd_block_cnt <= {PERF_CNT_W{1'b0}};
    end else if (clr_s) begin
      perf_conflict_cnt <= {PERF_CNT_W{1'b0}};
      perf_rd_block_cnt <= {PERF_CNT_W{1'b0}};
    end else if (active_s) begin
      if (wr_valid && rd_addr_valid && (perf_conflict_cnt != {PERF_CNT_W{1'b1}})) begin
        perf_conflict_cnt <= perf_conflict_cnt + PERF_CNT_W'(1);
      end
      if (rd_addr_valid && !rd_ok_s && (perf_rd_block_cnt != {PERF_CNT_W{1'b1}})) begin
        perf_rd_block_cnt <= perf_rd_block_cnt + PERF_CNT_W'(1);
      end
    end
  end
`endif

endmodule
